// File: rtl/gearbox_pkg.sv
// Shared definitions for the gearbox packet path.
// Contents: default data width, output header magic, read-side FSM state encoding.
package gearbox_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam logic [15:0] HDR_MAGIC  = 16'hA55A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_LOAD = 2'd2,
      ST_DATA = 2'd3
   } rd_state_e;

endpackage

// File: rtl/gearbox_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port, 1-cycle registered read.
// Ports: clk; wr_en_i/wr_addr_i/wr_data_i write port;
//        rd_en_i/rd_addr_i read request; rd_data_o word read on the previous enabled cycle.
module gearbox_sdp_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Storage array and read register; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gearbox_pkt_fifo_32.sv
// Store-and-forward packet FIFO behind the 24->32 gearbox. Whole frames are buffered,
// released on a valid/ready master only once complete; frames that do not fit are dropped.
// Optional macro GEARBOX_PKT_LEN_HDR_EN prefixes each output frame with {16'hA55A, length}.
// Ports: clk; reset (sync, active-low); data_in/data_en/data_in_last input stream;
//        m_data/m_valid/m_last/m_ready output stream; pkt_drop pulse; drop_cnt saturating count.
module gearbox_pkt_fifo_32
   import gearbox_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned LEN_ADDR_W = 4,
   parameter int unsigned LEN_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_en,
   input  logic              data_in_last,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              pkt_drop,
   output logic [15:0]       drop_cnt
);

   localparam int unsigned PTR_W     = ADDR_W + 1;
   localparam int unsigned DEPTH     = 1 << ADDR_W;
   localparam int unsigned LPTR_W    = LEN_ADDR_W + 1;
   localparam int unsigned LEN_DEPTH = 1 << LEN_ADDR_W;
`ifdef GEARBOX_PKT_LEN_HDR_EN
   localparam rd_state_e ST_FIRST = ST_HDR;
`else
   localparam rd_state_e ST_FIRST = ST_LOAD;
`endif

   // write side
   logic [PTR_W-1:0]  wr_spec_q, wr_commit_q, rd_ptr_q, rd_addr_q, fill_c;
   logic              ram_full_c, len_full_c, dropping_q;
   logic              ram_we_c, commit_c, drop_c, start_drop_c;
   logic [LEN_W-1:0]  frame_len_q;
   logic              pkt_drop_q;
   logic [15:0]       drop_cnt_q;
   // length FIFO
   logic [LEN_W-1:0]  len_mem_q [LEN_DEPTH];
   logic [LPTR_W-1:0] len_wp_q, len_rp_q;
   logic              len_avail_q;
   logic [LEN_W-1:0]  len_head_c, first_len_c;
   // read side
   rd_state_e         state_q, state_d;
   logic              pop_len_c, first_rd_c, rd_en_c, rd_last_c, out_pop_c, out_is_hdr_c;
   logic [LEN_W-1:0]  iss_left_q, iss_left_d;
   logic [1:0]        occ_c;
   logic              rv_q, rl_q;
   logic [DATA_W-1:0] ram_rd_data;
   logic              in_v_c, in_last_c;
   logic [DATA_W-1:0] in_data_c;
   logic [DATA_W-1:0] m_data_q, pf_data_q;
   logic              m_valid_q, m_last_q, pf_valid_q, pf_last_q;
`ifdef GEARBOX_PKT_LEN_HDR_EN
   logic              hdr_inj_c, m_hdr_q;
   logic [LEN_W-1:0]  frm_len_q;
`endif

   assign fill_c     = wr_spec_q - rd_ptr_q;
   assign ram_full_c = (fill_c == PTR_W'(DEPTH));
   assign len_full_c = ((len_wp_q - len_rp_q) == LPTR_W'(LEN_DEPTH));
   assign len_head_c = len_mem_q[len_rp_q[LEN_ADDR_W-1:0]];
   assign out_pop_c  = m_valid_q & m_ready;

   // Input word classification: write, commit, start dropping, or drop at last.
   always_comb begin
      ram_we_c     = 1'b0;
      commit_c     = 1'b0;
      drop_c       = 1'b0;
      start_drop_c = 1'b0;
      if (data_en) begin
         if (data_in_last) begin
            if (!dropping_q && !ram_full_c && !len_full_c) begin
               ram_we_c = 1'b1;
               commit_c = 1'b1;
            end else begin
               drop_c = 1'b1;
            end
         end else if (!dropping_q) begin
            if (ram_full_c) start_drop_c = 1'b1;
            else            ram_we_c     = 1'b1;
         end
      end
   end

   // Write pointers, drop tracking and drop counter; a drop rewinds to the last commit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_spec_q   <= '0;
         wr_commit_q <= '0;
         dropping_q  <= 1'b0;
         frame_len_q <= '0;
         pkt_drop_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         pkt_drop_q <= drop_c;
         if (drop_c) begin
            wr_spec_q  <= wr_commit_q;
            dropping_q <= 1'b0;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         end else begin
            if (ram_we_c)     wr_spec_q  <= wr_spec_q + PTR_W'(1);
            if (start_drop_c) dropping_q <= 1'b1;
         end
         if (commit_c) wr_commit_q <= wr_spec_q + PTR_W'(1);
         if (data_en && data_in_last) frame_len_q <= '0;
         else if (ram_we_c)           frame_len_q <= frame_len_q + LEN_W'(1);
      end
   end

   // Length FIFO; the availability flag is registered so the read side sees a commit one cycle later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         len_wp_q    <= '0;
         len_rp_q    <= '0;
         len_avail_q <= 1'b0;
         for (int unsigned i = 0; i < LEN_DEPTH; i++) len_mem_q[i] <= '0;
      end else begin
         if (commit_c) begin
            len_mem_q[len_wp_q[LEN_ADDR_W-1:0]] <= frame_len_q + LEN_W'(1);
            len_wp_q <= len_wp_q + LPTR_W'(1);
         end
         if (pop_len_c) len_rp_q <= len_rp_q + LPTR_W'(1);
         len_avail_q <= (len_wp_q != len_rp_q);
      end
   end

   gearbox_sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (ram_we_c),
      .wr_addr_i (wr_spec_q[ADDR_W-1:0]),
      .wr_data_i (data_in),
      .rd_en_i   (rd_en_c),
      .rd_addr_i (rd_addr_q[ADDR_W-1:0]),
      .rd_data_o (ram_rd_data)
   );

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Read FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (len_avail_q) state_d = ST_FIRST;
         ST_HDR:  state_d = ST_LOAD;
         ST_LOAD: state_d = ST_DATA;
         ST_DATA: if (out_pop_c && m_last_q) state_d = len_avail_q ? ST_FIRST : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Read FSM outputs: length pop, first RAM read of a frame, header injection.
   always_comb begin
      pop_len_c  = 1'b0;
      first_rd_c = 1'b0;
`ifdef GEARBOX_PKT_LEN_HDR_EN
      hdr_inj_c  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: pop_len_c = len_avail_q;
         ST_DATA: pop_len_c = out_pop_c & m_last_q & len_avail_q;
`ifdef GEARBOX_PKT_LEN_HDR_EN
         ST_HDR: begin
            hdr_inj_c  = 1'b1;
            first_rd_c = 1'b1;
         end
`endif
         default: ;
      endcase
`ifndef GEARBOX_PKT_LEN_HDR_EN
      first_rd_c = pop_len_c;
`endif
   end

`ifdef GEARBOX_PKT_LEN_HDR_EN
   assign first_len_c  = frm_len_q;
   assign out_is_hdr_c = m_hdr_q;
   assign in_v_c       = rv_q | hdr_inj_c;
   assign in_last_c    = rl_q & ~hdr_inj_c;
   assign in_data_c    = hdr_inj_c ? DATA_W'({HDR_MAGIC, 16'(frm_len_q)}) : ram_rd_data;

   // Frame length kept for the header word and first read; header-in-output-register flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         frm_len_q <= '0;
         m_hdr_q   <= 1'b0;
      end else begin
         if (pop_len_c) frm_len_q <= len_head_c;
         if (!(m_valid_q && !out_pop_c)) m_hdr_q <= ~pf_valid_q & hdr_inj_c;
      end
   end
`else
   assign first_len_c  = len_head_c;
   assign out_is_hdr_c = 1'b0;
   assign in_v_c       = rv_q;
   assign in_last_c    = rl_q;
   assign in_data_c    = ram_rd_data;
`endif

   // RAM read issue: a new read only when the output register, prefetch and in-flight read leave room.
   always_comb begin
      occ_c      = 2'(m_valid_q & ~out_pop_c) + 2'(pf_valid_q) + 2'(rv_q);
      rd_en_c    = 1'b0;
      rd_last_c  = 1'b0;
      iss_left_d = iss_left_q;
      if (first_rd_c) begin
         rd_en_c    = 1'b1;
         rd_last_c  = (first_len_c == LEN_W'(1));
         iss_left_d = first_len_c - LEN_W'(1);
      end else if ((iss_left_q != '0) && (occ_c < 2'd2)) begin
         rd_en_c    = 1'b1;
         rd_last_c  = (iss_left_q == LEN_W'(1));
         iss_left_d = iss_left_q - LEN_W'(1);
      end
   end

   // Output register plus one-word prefetch; the head holds while stalled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         rd_addr_q  <= '0;
         iss_left_q <= '0;
         rv_q       <= 1'b0;
         rl_q       <= 1'b0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         pf_data_q  <= '0;
         pf_valid_q <= 1'b0;
         pf_last_q  <= 1'b0;
      end else begin
         iss_left_q <= iss_left_d;
         rv_q       <= rd_en_c;
         rl_q       <= rd_last_c;
         if (rd_en_c) rd_addr_q <= rd_addr_q + PTR_W'(1);
         if (out_pop_c && !out_is_hdr_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (m_valid_q && !out_pop_c) begin
            if (!pf_valid_q && in_v_c) begin
               pf_data_q  <= in_data_c;
               pf_last_q  <= in_last_c;
               pf_valid_q <= 1'b1;
            end
         end else if (pf_valid_q) begin
            m_data_q   <= pf_data_q;
            m_last_q   <= pf_last_q;
            m_valid_q  <= 1'b1;
            pf_valid_q <= in_v_c;
            if (in_v_c) begin
               pf_data_q <= in_data_c;
               pf_last_q <= in_last_c;
            end
         end else begin
            m_valid_q <= in_v_c;
            m_last_q  <= in_v_c & in_last_c;
            if (in_v_c) m_data_q <= in_data_c;
         end
      end
   end

   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign m_last   = m_last_q;
   assign pkt_drop = pkt_drop_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_gearbox_pkt_fifo_32.sv
// Scoreboard bench for gearbox_pkt_fifo_32 (ADDR_W=3, 8-word data RAM).
// Expected beats are queued by the stimulus; a negedge monitor pops and compares handshakes.
// When GEARBOX_PKT_LEN_HDR_EN is defined the expected stream includes the header word.
module tb_gearbox_pkt_fifo_32;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        data_en, data_in_last;
   logic [31:0] m_data;
   logic        m_valid, m_last, m_ready;
   logic        pkt_drop;
   logic [15:0] drop_cnt;

   int          n_err = 0;
   int          n_checks = 0;
   int          drop_pulses = 0;
   logic [31:0] exp_q [$];
   logic        exp_l [$];

   always #5 clk = ~clk;

   gearbox_pkt_fifo_32 #(
      .DATA_W     (32),
      .ADDR_W     (3),
      .LEN_ADDR_W (4),
      .LEN_W      (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .data_en      (data_en),
      .data_in_last (data_in_last),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_last       (m_last),
      .m_ready      (m_ready),
      .pkt_drop     (pkt_drop),
      .drop_cnt     (drop_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Sends n words base..base+n-1; call and return at posedge+1.
   task automatic send_frame(input logic [31:0] base, input int n, input bit keep);
      if (keep) begin
`ifdef GEARBOX_PKT_LEN_HDR_EN
         exp_q.push_back({16'hA55A, 16'(n)});
         exp_l.push_back(1'b0);
`endif
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(base + 32'(i));
            exp_l.push_back(i == n - 1);
         end
      end
      for (int i = 0; i < n; i++) begin
         data_in      = base + 32'(i);
         data_en      = 1'b1;
         data_in_last = (i == n - 1);
         @(posedge clk); #1;
      end
      data_en      = 1'b0;
      data_in_last = 1'b0;
   endtask

   task automatic drain(input string name);
      int c = 0;
      while (exp_q.size() != 0 && c < 500) begin
         @(posedge clk); #1;
         c++;
      end
      repeat (3) begin @(posedge clk); #1; end
      chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_idle"}, 32'(m_valid), 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b0;
      repeat (cycles) begin @(posedge clk); #1; end
      reset = 1'b1;
   endtask

   // Monitor: scoreboard compare, hold-while-stalled, no intra-frame gap, drop pulse count.
   initial begin : monitor
      logic [31:0] pd, ed;
      logic        pl, el;
      bit          stalled, prev_mid;
      stalled  = 1'b0;
      prev_mid = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stalled  = 1'b0;
            prev_mid = 1'b0;
         end else begin
            if (pkt_drop) drop_pulses++;
            if (stalled) begin
               chk("hold_valid", 32'(m_valid), 32'd1);
               chk("hold_data", m_data, pd);
               chk("hold_last", 32'(m_last), 32'(pl));
            end
            if (prev_mid) chk("no_gap", 32'(m_valid), 32'd1);
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL unexpected_beat: got %h expected none at %0t", m_data, $time);
               end else begin
                  ed = exp_q.pop_front();
                  el = exp_l.pop_front();
                  chk("beat_data", m_data, ed);
                  chk("beat_last", 32'(m_last), 32'(el));
               end
            end
            stalled  = m_valid && !m_ready;
            prev_mid = m_valid && m_ready && !m_last;
            pd       = m_data;
            pl       = m_last;
         end
      end
   end

   initial begin : stim
      int lat;
      int c;
      data_in      = '0;
      data_en      = 1'b0;
      data_in_last = 1'b0;
      m_ready      = 1'b1;
      reset        = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_last", 32'(m_last), 32'd0);
      chk("rst_data", m_data, 32'd0);
      chk("rst_drop", 32'(pkt_drop), 32'd0);
      chk("rst_cnt", 32'(drop_cnt), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // two 4-word frames, latency measured from the first last word
      send_frame(32'h1, 4, 1'b1);
      fork
         begin
            lat = 99;
            for (int k = 1; k <= 12; k++) begin
               @(posedge clk); #1;
               if (m_valid) begin
                  lat = k;
                  break;
               end
            end
         end
         send_frame(32'h5, 4, 1'b1);
      join
      chk("latency", 32'(lat), 32'd3);
      drain("two_frames");

      // single-word frame
      send_frame(32'hDEADBEEF, 1, 1'b1);
      drain("single");
      chk("single_cnt", 32'(drop_cnt), 32'd0);

      // oversize frame is dropped, next frame passes
      send_frame(32'h100, 10, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      chk("drop_pulses", 32'(drop_pulses), 32'd1);
      chk("drop_cnt", 32'(drop_cnt), 32'd1);
      send_frame(32'h200, 3, 1'b1);
      drain("after_drop");

      // three frames filling the RAM exactly, long stall then toggled ready
      m_ready = 1'b0;
      send_frame(32'h10, 3, 1'b1);
      send_frame(32'h20, 3, 1'b1);
      send_frame(32'h30, 2, 1'b1);
      repeat (20) begin @(posedge clk); #1; end
      chk("stall_valid", 32'(m_valid), 32'd1);
      c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         m_ready = ~m_ready;
         @(posedge clk); #1;
         c++;
      end
      m_ready = 1'b1;
      drain("stall");

      // reset mid-input
      data_in = 32'h300; data_en = 1'b1; data_in_last = 1'b0;
      @(posedge clk); #1;
      data_in = 32'h301;
      @(posedge clk); #1;
      data_en = 1'b0;
      do_reset(2);
      @(posedge clk); #1;
      chk("rst_in_valid", 32'(m_valid), 32'd0);
      chk("rst_in_cnt", 32'(drop_cnt), 32'd0);
      send_frame(32'h400, 3, 1'b1);
      drain("after_rst_in");

      // reset mid-output
      m_ready = 1'b0;
      send_frame(32'h500, 4, 1'b1);
      c = 0;
      while (!m_valid && c < 20) begin
         @(posedge clk); #1;
         c++;
      end
      chk("mid_out_valid", 32'(m_valid), 32'd1);
      m_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      m_ready = 1'b0;
      exp_q.delete();
      exp_l.delete();
      do_reset(2);
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(m_valid), 32'd0);
      chk("rst_out_cnt", 32'(drop_cnt), 32'd0);
      m_ready = 1'b1;
      send_frame(32'h600, 4, 1'b1);
      drain("after_rst_out");

      // 5-word frame (carries the header beat when the header build is enabled)
      send_frame(32'h700, 5, 1'b1);
      drain("five");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gearbox_pkt_fifo_32.md
Name: gearbox_pkt_fifo_32

Overview:
Store-and-forward packet FIFO directly downstream of the 24->32 gearbox. It consumes the gearbox's 32-bit word stream (data/en/last, no backpressure) and buffers each frame whole. A frame is released on a valid/ready master interface only after its last word is received. A frame that cannot fit is dropped cleanly and counted.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 9, data RAM address width; depth = 2^ADDR_W words.
- LEN_ADDR_W, 4, length-FIFO address width; max stored frames = 2^LEN_ADDR_W.
- LEN_W, 16, frame length field width. Must satisfy LEN_W >= ADDR_W+1.

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: synchronous, active-low reset (0 = reset).
- data_in, input, DATA_W: word from the gearbox.
- data_en, input, 1: data_in valid this cycle.
- data_in_last, input, 1: last word of frame; qualified by data_en.
- m_data, output, DATA_W: output word.
- m_valid, output, 1: m_data valid.
- m_last, output, 1: last word of the output frame.
- m_ready, input, 1: downstream accepts when m_valid && m_ready.
- pkt_drop, output, 1: one-cycle pulse when a frame is dropped.
- drop_cnt, output, 16: saturating count of dropped frames.

Behaviour:
- Reset (reset==0 at a clk edge): all pointers, length FIFO, FSM, m_valid, m_last, m_data, pkt_drop and drop_cnt go to 0. Any partial input frame and any frame mid-output are discarded.
- Pointers are ADDR_W+1 bits with wrap. Fill = wr_spec - rd_ptr, using the registered rd_ptr, so a same-cycle read never creates space.
- Frame start is implicit: the first data_en after reset or after a data_en && data_in_last.
- Write, normal path: on data_en, if fill < 2^ADDR_W and not dropping, write RAM[wr_spec] and increment wr_spec.
- Write, overflow: on data_en with fill == 2^ADDR_W, enter dropping. All further words of that frame are ignored.
- Commit: on data_en && data_in_last, not dropping, space available, and length FIFO not full:
  - wr_commit <= wr_spec+1;
  - push length = words in frame (1..2^ADDR_W).
- Drop at last: if dropping, RAM full, or length FIFO full at the last word, do all of the following:
  - wr_spec <= wr_commit;
  - pkt_drop pulses the next cycle;
  - drop_cnt increments, saturating at 16'hFFFF;
  - dropping clears.
- Only committed data is ever readable.
- Single-word frame (first data_en with data_in_last): a valid frame of length 1.
- Read FSM states:
  - IDLE: if length FIFO is non-empty, pop the length, load remaining count, issue RAM read at rd_ptr, go to LOAD.
  - LOAD: RAM data (1-cycle read latency) is registered to m_data; m_valid=1; go to DATA.
  - DATA: on m_valid && m_ready, rd_ptr++. m_last=1 when remaining==1.
    - Not last: the next word is presented. A prefetch register sustains 1 word/cycle under continuous m_ready.
    - Last: go to IDLE (or straight to LOAD if another length is queued).
- m_data and m_last hold stable while m_valid && !m_ready.
- Latency: with an empty FIFO and m_ready=1, m_valid rises exactly 3 cycles after the clk edge that samples the last input word.
- Frames exit in arrival order. There are no gaps between words within a frame when m_ready stays high. The gap between frames is at most 1 cycle.

Optional Feature:
- Macro: GEARBOX_PKT_LEN_HDR_EN.
- Defined: each output frame is preceded by a header word {16'hA55A, zero-extended length[15:0]} with m_valid=1 and m_last=0. The FSM gains a HDR state between IDLE and LOAD. Latency becomes 3 cycles to the header and 4 cycles to the first data word.
- Undefined: no header; behaviour as above.

Decomposition:
- Shared package gearbox_pkg holds:
  - DATA_W default;
  - header magic 16'hA55A;
  - FSM state enum (IDLE, HDR, LOAD, DATA).
- One sub-module: gearbox_sdp_ram, a simple dual-port RAM with 1-cycle registered read, used for the data RAM. The length FIFO is a small inline register array.

Test Plan:
- Two 4-word frames (0x1..0x4, 0x5..0x8), m_ready=1 -> m_valid rises 3 cycles after the first last. Eight words are output contiguously in order; m_last on 0x4 and 0x8.
- Single-word frame 0xDEADBEEF with data_en && data_in_last -> one output beat with m_last=1; drop_cnt=0.
- ADDR_W=3, 10-word frame -> pkt_drop pulses once; drop_cnt=1; nothing output. A following 3-word frame is output intact.
- Queue 3 frames, hold m_ready=0 for 20 cycles, then toggle 1/0 -> m_data stable while stalled; all words delivered exactly once, in order.
- Assert reset=0 mid-input and again mid-output, for 2 cycles -> m_valid=0 and drop_cnt=0 the cycle after. The next full frame passes cleanly.
- With GEARBOX_PKT_LEN_HDR_EN, a 5-word frame -> first beat is 0xA55A0005, then 5 data beats; m_last only on beat 6.
